vesa_pattern_gen: RTL and testbench

Parametrised debug pattern source for the VESA video path. Tracks `vs`/`de` timing, keeps pixel/line/frame counters, and drives a registered `vesa_data` word from one of eight selectable test patterns, with timing outputs delayed to stay aligned. It sits where a scaler or camera output would normally feed the HDMI/VESA transmitter, for bring-up and link debug.

---
 rtl/vesa_dbg_pkg.sv | 30 +++
 rtl/vesa_pattern_gen_if.sv | 26 ++
 rtl/vesa_timing_tracker.sv | 89 ++++++++
 rtl/vesa_pattern_gen.sv | 111 +++++++++++
 tb/tb_vesa_pattern_gen.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vesa_dbg_pkg.sv
// Shared definitions for the VESA debug pattern source: pattern mode codes,
// colour-bar count and RGB field-width helpers.
package vesa_dbg_pkg;

    typedef enum logic [2:0] {
        MODE_INC_LINE  = 3'd0,
        MODE_INC_FRAME = 3'd1,
        MODE_COLOR_BAR = 3'd2,
        MODE_CHECKER   = 3'd3,
        MODE_H_RAMP    = 3'd4,
        MODE_V_RAMP    = 3'd5,
        MODE_FRAME_ID  = 3'd6,
        MODE_SOLID     = 3'd7
    } mode_t;

    localparam int BAR_NUM = 8;

    function automatic int r_width(input int dw);
        return dw / 3;
    endfunction

    function automatic int g_width(input int dw);
        return dw - 2 * (dw / 3);
    endfunction

    function automatic int b_width(input int dw);
        return dw / 3;
    endfunction

endpackage

// File: rtl/vesa_pattern_gen_if.sv
// Video timing and pattern bus between a timing source and the pattern generator.
interface vesa_pattern_gen_if #(
    parameter int DATA_W = 16,
    parameter int F_W    = 8
);
    logic              vs;
    logic              hs;
    logic              de;
    logic [2:0]        mode;
    logic [DATA_W-1:0] seed;
    logic              out_vs;
    logic              out_hs;
    logic              out_de;
    logic [DATA_W-1:0] vesa_data;
    logic [F_W-1:0]    frame_cnt;

    modport master (
        output vs, hs, de, mode, seed,
        input  out_vs, out_hs, out_de, vesa_data, frame_cnt
    );

    modport slave (
        input  vs, hs, de, mode, seed,
        output out_vs, out_hs, out_de, vesa_data, frame_cnt
    );
endinterface

// File: rtl/vesa_timing_tracker.sv
// Follows vs/de timing: pixel/line/bar/frame counters, the incrementing
// accumulator, and the per-frame mode/seed latch.
module vesa_timing_tracker
    import vesa_dbg_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int X_W    = 12,
    parameter int Y_W    = 12,
    parameter int F_W    = 8,
    parameter int BAR_W  = 160
) (
    input  logic              pix_clk,
    input  logic              rst,
    input  logic              vs,
    input  logic              de,
    input  logic [2:0]        mode,
    input  logic [DATA_W-1:0] seed,
    output logic [X_W-1:0]    x,
    output logic [Y_W-1:0]    y,
    output logic [DATA_W-1:0] acc,
    output logic [2:0]        bar_idx,
    output logic [F_W-1:0]    frame_cnt,
    output mode_t             mode_q,
    output logic [DATA_W-1:0] seed_q
);

    localparam int BC_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    logic            vs_d;
    logic            de_d;
    logic            vs_rise;
    logic            de_fall;
    logic [BC_W-1:0] bar_cnt;

    function automatic logic [2:0] sat_inc(input logic [2:0] b);
        return (b == 3'(BAR_NUM - 1)) ? b : b + 3'd1;
    endfunction

    assign vs_rise = vs & ~vs_d;
    assign de_fall = ~de & de_d;

    // Priority: vs level > active pixel > end of line
    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            vs_d      <= 1'b0;
            de_d      <= 1'b0;
            x         <= '0;
            y         <= '0;
            acc       <= '0;
            bar_cnt   <= '0;
            bar_idx   <= '0;
            frame_cnt <= '0;
            mode_q    <= MODE_INC_LINE;
            seed_q    <= '0;
        end else begin
            vs_d <= vs;
            de_d <= de;
            if (vs_rise) begin
                mode_q    <= mode_t'(mode);
                seed_q    <= seed;
                frame_cnt <= frame_cnt + F_W'(1);
            end
            if (vs) begin
                x       <= '0;
                y       <= '0;
                acc     <= vs_rise ? seed : seed_q;
                bar_cnt <= '0;
                bar_idx <= '0;
            end else if (de) begin
                x   <= x + X_W'(1);
                acc <= acc + DATA_W'(1);
                if (bar_cnt == BC_W'(BAR_W - 1)) begin
                    bar_cnt <= '0;
                    bar_idx <= sat_inc(bar_idx);
                end else begin
                    bar_cnt <= bar_cnt + BC_W'(1);
                end
            end else if (de_fall) begin
                x       <= '0;
                y       <= y + Y_W'(1);
                bar_cnt <= '0;
                bar_idx <= '0;
                if (mode_q == MODE_INC_LINE)
                    acc <= seed_q;
            end
        end
    end

endmodule

// File: rtl/vesa_pattern_gen.sv
// Debug pattern source: selects one of eight test patterns from the tracked
// timing and registers it alongside the delayed vs/hs/de.
module vesa_pattern_gen
    import vesa_dbg_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int X_W     = 12,
    parameter int Y_W     = 12,
    parameter int F_W     = 8,
    parameter int BAR_W   = 160,
    parameter int SQ_LOG2 = 5
) (
    input  logic             pix_clk,
    input  logic             rst,
    vesa_pattern_gen_if.slave bus
);

    localparam int G_W = g_width(DATA_W);
    localparam int B_W = b_width(DATA_W);

    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [DATA_W-1:0] acc;
    logic [2:0]        bar_idx;
    logic [F_W-1:0]    frame_cnt;
    mode_t             mode_q;
    logic [DATA_W-1:0] seed_q;
    logic [DATA_W-1:0] pat_p0;
    logic [DATA_W-1:0] data_p1;
    logic              vld_p1;
    logic              vs_p1;
    logic              hs_p1;

    vesa_timing_tracker #(
        .DATA_W (DATA_W),
        .X_W    (X_W),
        .Y_W    (Y_W),
        .F_W    (F_W),
        .BAR_W  (BAR_W)
    ) u_tracker (
        .pix_clk   (pix_clk),
        .rst       (rst),
        .vs        (bus.vs),
        .de        (bus.de),
        .mode      (bus.mode),
        .seed      (bus.seed),
        .x         (x),
        .y         (y),
        .acc       (acc),
        .bar_idx   (bar_idx),
        .frame_cnt (frame_cnt),
        .mode_q    (mode_q),
        .seed_q    (seed_q)
    );

    // Standard bar order (white, yellow, cyan, green, magenta, red, blue,
    // black): G follows c[2], R follows c[1], B follows c[0].
    function automatic logic [DATA_W-1:0] bar_color(input logic [2:0] idx);
        logic [2:0]        c;
        logic [DATA_W-1:0] v;
        c = 3'd7 - idx;
        v = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i < B_W)
                v[i] = c[0];
            else if (i < B_W + G_W)
                v[i] = c[2];
            else
                v[i] = c[1];
        end
        return v;
    endfunction

    // Stage p0: pattern value from current counters
    always_comb begin
        pat_p0 = '0;
        case (mode_q)
            MODE_INC_LINE,
            MODE_INC_FRAME: pat_p0 = acc;
            MODE_COLOR_BAR: pat_p0 = bar_color(bar_idx);
            MODE_CHECKER:   pat_p0 = (x[SQ_LOG2] ^ y[SQ_LOG2]) ? '1 : '0;
            MODE_H_RAMP:    pat_p0 = DATA_W'(x);
            MODE_V_RAMP:    pat_p0 = DATA_W'(y);
            MODE_FRAME_ID:  pat_p0 = DATA_W'(frame_cnt);
            MODE_SOLID:     pat_p0 = seed_q;
            default:        pat_p0 = '0;
        endcase
    end

    // Stage p1: registered outputs, blanked outside active video
    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
            vs_p1   <= 1'b0;
            hs_p1   <= 1'b0;
        end else begin
            data_p1 <= (bus.de && !bus.vs) ? pat_p0 : '0;
            vld_p1  <= bus.de;
            vs_p1   <= bus.vs;
            hs_p1   <= bus.hs;
        end
    end

    assign bus.vesa_data = data_p1;
    assign bus.out_de    = vld_p1;
    assign bus.out_vs    = vs_p1;
    assign bus.out_hs    = hs_p1;
    assign bus.frame_cnt = frame_cnt;

endmodule

// File: tb/tb_vesa_pattern_gen.sv
// Table-driven bench for vesa_pattern_gen with a scoreboard of expected
// registered outputs, plus hand-written reset sequences.
module tb_vesa_pattern_gen;

    localparam int DATA_W  = 16;
    localparam int X_W     = 12;
    localparam int Y_W     = 12;
    localparam int F_W     = 8;
    localparam int BAR_W   = 2;
    localparam int SQ_LOG2 = 1;

    typedef struct {
        logic        vs;
        logic        hs;
        logic        de;
        logic [2:0]  mode;
        logic [15:0] seed;
        logic [15:0] want;
    } vec_t;

    typedef struct {
        logic        vs;
        logic        hs;
        logic        de;
        logic [15:0] data;
    } exp_t;

    logic pix_clk = 1'b0;
    logic rst;

    vec_t        tbl[$];
    exp_t        sbq[$];
    exp_t        mon_e;
    int          errors = 0;
    int          checks = 0;
    logic [2:0]  cur_mode;
    logic [15:0] cur_seed;
    int          fc_exp;
    logic [15:0] bar_exp [16];

    always #5 pix_clk = ~pix_clk;

    vesa_pattern_gen_if #(.DATA_W(DATA_W), .F_W(F_W)) bus ();

    vesa_pattern_gen #(
        .DATA_W  (DATA_W),
        .X_W     (X_W),
        .Y_W     (Y_W),
        .F_W     (F_W),
        .BAR_W   (BAR_W),
        .SQ_LOG2 (SQ_LOG2)
    ) dut (
        .pix_clk (pix_clk),
        .rst     (rst),
        .bus     (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h required %h", name, $time, act, req);
        end
    endtask

    task automatic add(input logic vs, input logic hs, input logic de, input logic [15:0] want);
        tbl.push_back('{vs, hs, de, cur_mode, cur_seed, want});
    endtask

    task automatic add_gap(input int n);
        for (int i = 0; i < n; i++) add(1'b0, 1'b1, 1'b0, 16'h0000);
    endtask

    task automatic add_vs();
        add(1'b1, 1'b0, 1'b0, 16'h0000);
        add(1'b1, 1'b0, 1'b0, 16'h0000);
        add_gap(1);
        fc_exp++;
    endtask

    task automatic run_tbl();
        int n;
        foreach (tbl[i]) begin
            @(negedge pix_clk);
            bus.vs   = tbl[i].vs;
            bus.hs   = tbl[i].hs;
            bus.de   = tbl[i].de;
            bus.mode = tbl[i].mode;
            bus.seed = tbl[i].seed;
            sbq.push_back('{tbl[i].vs, tbl[i].hs, tbl[i].de, tbl[i].want});
        end
        n = 0;
        while (sbq.size() != 0 && n < 10) begin
            @(posedge pix_clk);
            #2;
            n++;
        end
        chk("scoreboard_drain", sbq.size(), 0);
        tbl.delete();
    endtask

    always @(posedge pix_clk) begin
        #1;
        if (sbq.size() != 0) begin
            mon_e = sbq.pop_front();
            chk("vesa_data", bus.vesa_data, mon_e.data);
            chk("out_de", bus.out_de, mon_e.de);
            chk("out_vs", bus.out_vs, mon_e.vs);
            chk("out_hs", bus.out_hs, mon_e.hs);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bar_exp = '{16'hFFFF, 16'hFFFF, 16'hFFE0, 16'hFFE0, 16'h07FF, 16'h07FF, 16'h07E0, 16'h07E0,
                    16'hF81F, 16'hF81F, 16'hF800, 16'hF800, 16'h001F, 16'h001F, 16'h0000, 16'h0000};
        rst      = 1'b1;
        bus.vs   = 1'b1;
        bus.hs   = 1'b1;
        bus.de   = 1'b1;
        bus.mode = 3'd7;
        bus.seed = 16'hFFFF;
        repeat (3) @(posedge pix_clk);
        #1;
        chk("rst_vesa_data", bus.vesa_data, 0);
        chk("rst_out_de", bus.out_de, 0);
        chk("rst_out_vs", bus.out_vs, 0);
        chk("rst_out_hs", bus.out_hs, 0);
        chk("rst_frame_cnt", bus.frame_cnt, 0);
        @(negedge pix_clk);
        bus.vs = 1'b0; bus.hs = 1'b0; bus.de = 1'b0;
        rst    = 1'b0;
        fc_exp = 0;

        // Mode 0: accumulator reloads at each line end
        cur_mode = 3'd0; cur_seed = 16'hA500;
        add_vs();
        for (int l = 0; l < 3; l++) begin
            for (int p = 0; p < 4; p++) add(1'b0, 1'b0, 1'b1, 16'hA500 + 16'(p));
            add_gap(2);
        end
        run_tbl();
        chk("frame_cnt_m0", bus.frame_cnt, fc_exp);

        // Mode 1: accumulator runs across lines, restarts on new frame
        cur_mode = 3'd1;
        add_vs();
        for (int l = 0; l < 3; l++) begin
            for (int p = 0; p < 4; p++) add(1'b0, 1'b0, 1'b1, 16'hA500 + 16'(l * 4 + p));
            add_gap(2);
        end
        run_tbl();
        chk("frame_cnt_m1a", bus.frame_cnt, fc_exp);
        add_vs();
        for (int p = 0; p < 4; p++) add(1'b0, 1'b0, 1'b1, 16'hA500 + 16'(p));
        add_gap(2);
        run_tbl();
        chk("frame_cnt_m1b", bus.frame_cnt, fc_exp);

        // Mode 2: colour bars, two pixels per bar
        cur_mode = 3'd2;
        add_vs();
        for (int p = 0; p < 16; p++) add(1'b0, 1'b0, 1'b1, bar_exp[p]);
        add_gap(2);
        run_tbl();

        // Mode 3: checker with 2-pixel squares
        cur_mode = 3'd3;
        add_vs();
        for (int l = 0; l < 3; l++) begin
            for (int p = 0; p < 8; p++)
                add(1'b0, 1'b0, 1'b1, ((((p >> 1) ^ (l >> 1)) & 1) != 0) ? 16'hFFFF : 16'h0000);
            add_gap(2);
        end
        run_tbl();

        // Mode 0 -> 7 switched mid-line: takes effect only next frame
        cur_mode = 3'd0; cur_seed = 16'h1234;
        add_vs();
        for (int p = 0; p < 4; p++) begin
            if (p == 2) cur_mode = 3'd7;
            add(1'b0, 1'b0, 1'b1, 16'h1234 + 16'(p));
        end
        add_gap(2);
        for (int p = 0; p < 4; p++) add(1'b0, 1'b0, 1'b1, 16'h1234 + 16'(p));
        add_gap(2);
        add_vs();
        for (int p = 0; p < 4; p++) add(1'b0, 1'b0, 1'b1, 16'h1234);
        add_gap(2);
        run_tbl();
        chk("frame_cnt_m7", bus.frame_cnt, fc_exp);

        // Mode 5: line ramp, single-cycle de pulses, de fall coinciding with vs rise
        cur_mode = 3'd5;
        add_vs();
        for (int p = 0; p < 2; p++) add(1'b0, 1'b0, 1'b1, 16'd0);
        add_gap(1);
        for (int p = 0; p < 2; p++) add(1'b0, 1'b0, 1'b1, 16'd1);
        add_gap(1);
        for (int k = 2; k < 5; k++) begin
            add(1'b0, 1'b0, 1'b1, 16'(k));
            add_gap(1);
        end
        add(1'b0, 1'b0, 1'b1, 16'd5);
        add(1'b1, 1'b0, 1'b0, 16'd0);
        add(1'b1, 1'b0, 1'b0, 16'd0);
        fc_exp++;
        add_gap(1);
        for (int p = 0; p < 2; p++) add(1'b0, 1'b0, 1'b1, 16'd0);
        add_gap(2);
        run_tbl();

        // Mode 6: frame id
        cur_mode = 3'd6;
        add_vs();
        for (int p = 0; p < 3; p++) add(1'b0, 1'b0, 1'b1, 16'(fc_exp));
        add_gap(2);
        run_tbl();
        chk("frame_cnt_m6", bus.frame_cnt, fc_exp);

        // Mode 4 with reset asserted mid-line
        cur_mode = 3'd4;
        add_vs();
        for (int p = 0; p < 3; p++) add(1'b0, 1'b0, 1'b1, 16'(p));
        run_tbl();
        #1;
        chk("pre_rst_vesa_data", bus.vesa_data, 16'd2);
        rst = 1'b1;
        #1;
        chk("async_rst_vesa_data", bus.vesa_data, 0);
        chk("async_rst_out_de", bus.out_de, 0);
        chk("async_rst_frame_cnt", bus.frame_cnt, 0);
        @(negedge pix_clk);
        bus.de = 1'b0;
        repeat (2) @(posedge pix_clk);
        @(negedge pix_clk);
        rst    = 1'b0;
        fc_exp = 0;

        // After reset: vs with de high must not count; ramp restarts at 0
        add(1'b1, 1'b0, 1'b0, 16'd0);
        add(1'b1, 1'b0, 1'b1, 16'd0);
        for (int p = 0; p < 5; p++) add(1'b0, 1'b0, 1'b1, 16'(p));
        fc_exp++;
        add_gap(2);
        run_tbl();
        chk("frame_cnt_after_rst", bus.frame_cnt, fc_exp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
